// File: rtl/int_priority_arbiter_if.sv
// Memory-mapped register port used by the interrupt priority arbiter.
// Single-beat requests: valid qualifies w_en/addr/w_data; r_data is
// returned on the cycle after a read.
interface mem_if;
  typedef logic [31:0] word_t;

  logic  valid;
  logic  w_en;
  word_t addr;
  word_t w_data;
  word_t r_data;
  logic  ready;

  modport slave (
    input  valid,
    input  w_en,
    input  addr,
    input  w_data,
    output r_data,
    output ready
  );

  modport master (
    output valid,
    output w_en,
    output addr,
    output w_data,
    input  r_data,
    input  ready
  );
endinterface

// File: rtl/int_priority_arbiter.sv
// Interrupt priority arbiter: picks the highest-priority eligible source
// (round-robin among equals), drives the core interrupt line and offers a
// claim/complete register so software services one source at a time.
module int_priority_arbiter #(
  parameter int NUM_INT_SRCS = 8,
  parameter int PRIO_W       = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_INT_SRCS-1:0] i_pending,
  output logic                    o_int,
  output logic [4:0]              o_claim_id,
  mem_if.slave                    if_mem
);

  generate
    if (NUM_INT_SRCS < 1 || NUM_INT_SRCS > 31) begin : g_bad_num_srcs
      $error("int_priority_arbiter: NUM_INT_SRCS must be in 1..31");
    end
  endgenerate

  localparam logic [5:0] WORD_THRESHOLD  = 6'd0;
  localparam logic [5:0] WORD_CLAIM      = 6'd1;
  localparam logic [5:0] WORD_IN_SERVICE = 6'd2;
  localparam logic [5:0] WORD_PRIO_BASE  = 6'd16;

  typedef enum logic {ARB, SETTLE} state_t;
  state_t state_q, state_d;

  logic [PRIO_W-1:0]       r_threshold;
  logic [PRIO_W-1:0]       r_prio [NUM_INT_SRCS];
  logic [NUM_INT_SRCS-1:0] r_in_service;
  logic [4:0]              r_rr;
  logic                    r_best_valid;
  logic [4:0]              r_best_id;
  logic [31:0]             r_data;

  logic [5:0]        word_addr;
  logic              rd_en, wr_en, claim_rd, claim_ok;
  logic [31:0]       pend_ext, elig_ext;
  logic [PRIO_W-1:0] prio_ext [32];
  logic              cand_found;
  logic [4:0]        cand_id;
  logic [PRIO_W-1:0] cand_prio;
  logic [4:0]        rr_after_claim;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign word_addr     = if_mem.addr[7:2];
  assign rd_en         = if_mem.valid & ~if_mem.w_en;
  assign wr_en         = if_mem.valid & if_mem.w_en;
  assign if_mem.ready  = 1'b1;
  assign if_mem.r_data = r_data;
  assign unused_bits   = ^{if_mem.addr, if_mem.w_data};

  assign o_int      = r_best_valid;
  assign o_claim_id = r_best_valid ? r_best_id + 5'd1 : 5'd0;

  assign rr_after_claim = (r_best_id == 5'(NUM_INT_SRCS - 1)) ? 5'd0 : r_best_id + 5'd1;

  // Widen per-source state to 32 entries so 5-bit IDs can index it directly.
  always_comb begin
    pend_ext = '0;
    elig_ext = '0;
    for (int i = 0; i < 32; i++) prio_ext[i] = '0;
    for (int i = 0; i < NUM_INT_SRCS; i++) begin
      pend_ext[i] = i_pending[i];
      prio_ext[i] = r_prio[i];
      elig_ext[i] = i_pending[i] & ~r_in_service[i] & (r_prio[i] > r_threshold);
    end
  end

  // Scan from the rr pointer upward with wrap; strict '>' keeps the first tie.
  always_comb begin
    logic [5:0] idx;
    idx        = '0;
    cand_found = 1'b0;
    cand_id    = '0;
    cand_prio  = '0;
    for (int k = 0; k < NUM_INT_SRCS; k++) begin
      idx = {1'b0, r_rr} + 6'(k);
      if (idx >= 6'(NUM_INT_SRCS)) idx = idx - 6'(NUM_INT_SRCS);
      if (elig_ext[idx[4:0]] && (!cand_found || prio_ext[idx[4:0]] > cand_prio)) begin
        cand_found = 1'b1;
        cand_id    = idx[4:0];
        cand_prio  = prio_ext[idx[4:0]];
      end
    end
  end

  // Claim qualification and next state; a claim only succeeds in ARB and
  // only if the registered winner is still pending this cycle.
  always_comb begin
    state_d  = state_q;
    claim_rd = rd_en && (word_addr == WORD_CLAIM);
    claim_ok = 1'b0;
    if (state_q == ARB) begin
      claim_ok = claim_rd && r_best_valid && pend_ext[r_best_id];
      if (claim_ok) state_d = SETTLE;
    end else begin
      state_d = ARB;
    end
  end

  // Register read mux; unmapped words read as zero.
  always_comb begin
    rd_val = '0;
    case (word_addr)
      WORD_THRESHOLD:  rd_val = 32'(r_threshold);
      WORD_CLAIM:      rd_val = claim_ok ? 32'(r_best_id) + 32'd1 : 32'd0;
      WORD_IN_SERVICE: rd_val = 32'(r_in_service);
      default: begin
        for (int i = 0; i < NUM_INT_SRCS; i++) begin
          if (word_addr == WORD_PRIO_BASE + 6'(i)) rd_val = 32'(r_prio[i]);
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ARB;
    else          state_q <= state_d;
  end

  // Threshold and per-source priority registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_threshold <= '0;
      for (int i = 0; i < NUM_INT_SRCS; i++) r_prio[i] <= '0;
    end else if (wr_en) begin
      if (word_addr == WORD_THRESHOLD) r_threshold <= if_mem.w_data[PRIO_W-1:0];
      for (int i = 0; i < NUM_INT_SRCS; i++) begin
        if (word_addr == WORD_PRIO_BASE + 6'(i)) r_prio[i] <= if_mem.w_data[PRIO_W-1:0];
      end
    end
  end

  // In-service mask and round-robin pointer: set/advance on claim, clear on complete.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_service <= '0;
      r_rr         <= '0;
    end else begin
      if (claim_ok) begin
        r_rr <= rr_after_claim;
        for (int i = 0; i < NUM_INT_SRCS; i++) begin
          if (r_best_id == 5'(i)) r_in_service[i] <= 1'b1;
        end
      end
      if (wr_en && word_addr == WORD_CLAIM) begin
        for (int i = 0; i < NUM_INT_SRCS; i++) begin
          if (if_mem.w_data[4:0] == 5'(i + 1)) r_in_service[i] <= 1'b0;
        end
      end
    end
  end

  // Registered best candidate; SETTLE blanks it for one cycle after a claim.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_valid <= 1'b0;
      r_best_id    <= '0;
    end else if (state_q == SETTLE) begin
      r_best_valid <= 1'b0;
    end else begin
      r_best_valid <= cand_found;
      r_best_id    <= cand_id;
    end
  end

  // Read data register, loaded on every read request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_data <= '0;
    else if (rd_en) r_data <= rd_val;
  end

endmodule

// File: tb/tb_int_priority_arbiter.sv
// Directed bench for int_priority_arbiter: read expectations go through a
// scoreboard queue and are checked when r_data becomes valid.
module tb_int_priority_arbiter;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [N-1:0] i_pending;
  logic         o_int;
  logic [4:0]   o_claim_id;

  mem_if u_if ();

  int_priority_arbiter #(.NUM_INT_SRCS(N), .PRIO_W(3)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_pending  (i_pending),
    .o_int      (o_int),
    .o_claim_id (o_claim_id),
    .if_mem     (u_if)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A_THR   = 32'h00;
  localparam logic [31:0] A_CLAIM = 32'h04;
  localparam logic [31:0] A_INSVC = 32'h08;

  function automatic logic [31:0] a_prio(int i);
    return 32'h40 + 32'(4 * i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    u_if.valid  = 1'b1;
    u_if.w_en   = 1'b1;
    u_if.addr   = addr;
    u_if.w_data = data;
    tick(1);
    u_if.valid  = 1'b0;
    u_if.w_en   = 1'b0;
  endtask

  task automatic mem_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    sb_entry_t e;
    u_if.valid = 1'b1;
    u_if.w_en  = 1'b0;
    u_if.addr  = addr;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    tick(1);
    u_if.valid = 1'b0;
    e = sb.pop_front();
    check(e.tag, u_if.r_data, e.exp);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_pending   = '0;
    u_if.valid  = 1'b0;
    u_if.w_en   = 1'b0;
    u_if.addr   = '0;
    u_if.w_data = '0;
    #12;
    check("rst_o_int", 32'(o_int), 32'd0);
    check("rst_claim_id", 32'(o_claim_id), 32'd0);
    check("rst_r_data", u_if.r_data, 32'd0);
    check("ready_tied", 32'(u_if.ready), 32'd1);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Reset register values, unmapped access, upper bits masked
    mem_read(A_THR, 32'd0, "rst_threshold");
    mem_read(A_INSVC, 32'd0, "rst_in_service");
    mem_read(a_prio(5), 32'd0, "rst_prio5");
    mem_read(A_CLAIM, 32'd0, "claim_empty");
    mem_write(32'h0C, 32'hFFFF_FFFF);
    mem_read(32'h0C, 32'd0, "unmapped_read");
    mem_write(A_THR, 32'hFF);
    mem_read(A_THR, 32'd7, "thr_upper_bits");
    mem_write(A_THR, 32'd0);

    // Basic claim / complete
    mem_write(a_prio(3), 32'd2);
    i_pending = 8'h08;
    tick(1);
    check("basic_o_int", 32'(o_int), 32'd1);
    check("basic_claim_id", 32'(o_claim_id), 32'd4);
    mem_read(A_CLAIM, 32'd4, "basic_claim");
    mem_read(A_INSVC, 32'h08, "basic_in_service");
    tick(1);
    check("basic_o_int_in_service", 32'(o_int), 32'd0);
    mem_write(A_CLAIM, 32'd4);
    tick(1);
    check("basic_o_int_after_complete", 32'(o_int), 32'd1);
    i_pending = '0;
    mem_write(a_prio(3), 32'd0);

    // Priority order
    mem_write(a_prio(1), 32'd5);
    mem_write(a_prio(6), 32'd3);
    i_pending = 8'h42;
    tick(1);
    mem_read(A_CLAIM, 32'd2, "prio_claim_first");
    tick(2);
    mem_read(A_CLAIM, 32'd7, "prio_claim_second");
    tick(2);
    mem_read(A_CLAIM, 32'd0, "prio_claim_none");
    mem_write(A_CLAIM, 32'd2);
    mem_write(A_CLAIM, 32'd7);
    i_pending = '0;
    mem_write(a_prio(1), 32'd0);
    mem_write(a_prio(6), 32'd0);

    // Round-robin among equal priorities
    mem_write(a_prio(0), 32'd4);
    mem_write(a_prio(2), 32'd4);
    mem_write(a_prio(5), 32'd4);
    i_pending = 8'h25;
    tick(1);
    mem_read(A_CLAIM, 32'd1, "rr_claim_1");
    tick(2);
    mem_write(A_CLAIM, 32'd1);
    tick(1);
    mem_read(A_CLAIM, 32'd3, "rr_claim_2");
    tick(2);
    mem_write(A_CLAIM, 32'd3);
    tick(1);
    mem_read(A_CLAIM, 32'd6, "rr_claim_3");
    tick(2);
    mem_write(A_CLAIM, 32'd6);
    tick(1);
    mem_read(A_CLAIM, 32'd1, "rr_claim_4");
    tick(2);
    mem_write(A_CLAIM, 32'd1);
    i_pending = '0;
    mem_write(a_prio(0), 32'd0);
    mem_write(a_prio(2), 32'd0);
    mem_write(a_prio(5), 32'd0);

    // Threshold
    mem_write(a_prio(2), 32'd3);
    mem_write(A_THR, 32'd3);
    i_pending = 8'h04;
    tick(2);
    check("thr_equal_blocks", 32'(o_int), 32'd0);
    mem_write(A_THR, 32'd2);
    tick(1);
    check("thr_lower_o_int", 32'(o_int), 32'd1);
    check("thr_lower_claim_id", 32'(o_claim_id), 32'd3);
    mem_write(a_prio(2), 32'd0);
    tick(1);
    check("prio_zero_o_int", 32'(o_int), 32'd0);
    mem_read(A_THR, 32'd2, "thr_readback");
    mem_write(A_THR, 32'd0);
    tick(2);
    check("prio_zero_thr0_o_int", 32'(o_int), 32'd0);
    i_pending = '0;

    // Stale candidate: pending drops in the claim cycle
    mem_write(a_prio(4), 32'd1);
    i_pending = 8'h10;
    tick(1);
    check("stale_claim_id", 32'(o_claim_id), 32'd5);
    i_pending = 8'h00;
    mem_read(A_CLAIM, 32'd0, "stale_claim");
    mem_read(A_INSVC, 32'd0, "stale_in_service");
    mem_write(a_prio(0), 32'd1);
    i_pending = 8'h11;
    tick(1);
    check("stale_rr_claim_id", 32'(o_claim_id), 32'd5);

    // Back-to-back claim, ignored completes
    mem_read(A_CLAIM, 32'd5, "b2b_claim_first");
    mem_read(A_CLAIM, 32'd0, "b2b_claim_settle");
    tick(1);
    mem_write(A_CLAIM, 32'd0);
    mem_write(A_CLAIM, 32'd9);
    mem_read(A_INSVC, 32'h10, "complete_ignored");
    check("pre_reset_o_int", 32'(o_int), 32'd1);
    check("pre_reset_claim_id", 32'(o_claim_id), 32'd1);

    // Asynchronous reset pulse mid-cycle
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_o_int", 32'(o_int), 32'd0);
    check("async_rst_claim_id", 32'(o_claim_id), 32'd0);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    mem_read(A_INSVC, 32'd0, "post_rst_in_service");
    mem_read(a_prio(4), 32'd0, "post_rst_prio4");
    mem_read(a_prio(0), 32'd0, "post_rst_prio0");
    check("post_rst_o_int", 32'(o_int), 32'd0);
    i_pending = '0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
